// File: rtl/node_port_fifo.sv
// rtl/node_port_fifo.sv - buffered valid/ready channel feeding one node data port
//
// Purpose: small first-word-fall-through FIFO between a producer (neighbouring
// node or external pins) and one 4-bit port of a processor node. When empty,
// the output holds the last consumed word so the node port input stays stable.
// Occupancy and a high-water mark are exported for debug.
//
// Ports:
//   clk          input   clock
//   reset        input   synchronous, active-high reset
//   i_in_valid   input   producer has a word on i_in_data
//   i_in_data    input   word from producer
//   o_in_ready   output  FIFO can accept a word this cycle
//   o_out_valid  output  o_out_data is a fresh, unconsumed head word
//   o_out_data   output  head word when valid, last popped word otherwise
//   i_out_ready  input   node consumes the head word this cycle
//   o_count      output  current occupancy, 0..DEPTH
//   o_hwm        output  maximum occupancy since reset or clear
//   i_hwm_clear  input   synchronous clear of the high-water mark
module node_port_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_in_valid,
  input  logic [WIDTH-1:0] i_in_data,
  output logic             o_in_ready,
  output logic             o_out_valid,
  output logic [WIDTH-1:0] o_out_data,
  input  logic             i_out_ready,
  output logic [AW:0]      o_count,
  output logic [AW:0]      o_hwm,
  input  logic             i_hwm_clear
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW:0]      r_count;
  logic [AW:0]      r_hwm;
  logic [WIDTH-1:0] r_hold;

  logic             w_push;
  logic             w_pop;
  logic [AW:0]      w_count_next;

  // Flags decode from registered count only: a full FIFO refuses a push even
  // when a pop happens in the same cycle, keeping in_ready free of out_ready.
  assign o_in_ready  = (r_count != FULL);
  assign o_out_valid = (r_count != '0);
  assign o_out_data  = o_out_valid ? r_mem[r_rd_ptr] : r_hold;
  assign o_count     = r_count;
  assign o_hwm       = r_hwm;

  assign w_push = i_in_valid & o_in_ready;
  assign w_pop  = o_out_valid & i_out_ready;

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + (AW+1)'(1);
    end else if (w_pop && !w_push) begin
      w_count_next = r_count - (AW+1)'(1);
    end
  end

  // Storage is not reset; writes are suppressed during reset so in_valid is
  // ignored in that cycle.
  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_mem[r_wr_ptr] <= i_in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_hwm    <= '0;
      r_hold   <= '0;
    end else begin
      r_count <= w_count_next;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_hold   <= r_mem[r_rd_ptr];
      end
      // Clearing loads the next occupancy rather than zero so the mark never
      // under-reports what is currently queued.
      if (i_hwm_clear) begin
        r_hwm <= w_count_next;
      end else if (w_count_next > r_hwm) begin
        r_hwm <= w_count_next;
      end
    end
  end

endmodule

// File: tb/tb_node_port_fifo.sv
// tb/tb_node_port_fifo.sv - self-checking scoreboard bench for node_port_fifo
module tb_node_port_fifo;

  logic       clk;
  logic       reset;
  logic       i_in_valid;
  logic [3:0] i_in_data;
  logic       o_in_ready;
  logic       o_out_valid;
  logic [3:0] o_out_data;
  logic       i_out_ready;
  logic [2:0] o_count;
  logic [2:0] o_hwm;
  logic       i_hwm_clear;

  int n_cmp;
  int n_err;

  logic [3:0] q[$];
  int         m_count;
  int         m_hwm;
  logic [3:0] m_hold;

  node_port_fifo #(.WIDTH(4), .DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_in_valid  (i_in_valid),
    .i_in_data   (i_in_data),
    .o_in_ready  (o_in_ready),
    .o_out_valid (o_out_valid),
    .o_out_data  (o_out_data),
    .i_out_ready (i_out_ready),
    .o_count     (o_count),
    .o_hwm       (o_hwm),
    .i_hwm_clear (i_hwm_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  a_hold_data: assert property (@(posedge clk) disable iff (reset)
    (i_in_valid && !o_in_ready) |=> (!i_in_valid || $stable(i_in_data)));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance
  // the model with the handshake it predicts, then cross the edge.
  task automatic cycle(input logic v, input logic [3:0] d, input logic r, input logic c);
    logic       push;
    logic       pop;
    logic [3:0] exp_data;
    int         nxt;
    i_in_valid  = v;
    i_in_data   = d;
    i_out_ready = r;
    i_hwm_clear = c;
    #1;
    exp_data = m_hold;
    if (m_count != 0) exp_data = q[0];
    chk("count",     32'(o_count),     32'(m_count));
    chk("in_ready",  32'(o_in_ready),  32'(m_count != 4));
    chk("out_valid", 32'(o_out_valid), 32'(m_count != 0));
    chk("out_data",  32'(o_out_data),  32'(exp_data));
    chk("hwm",       32'(o_hwm),       32'(m_hwm));
    push = v && (m_count != 4);
    pop  = r && (m_count != 0);
    if (pop) m_hold = q.pop_front();
    if (push) q.push_back(d);
    nxt = m_count + (push ? 1 : 0) - (pop ? 1 : 0);
    if (c) m_hwm = nxt;
    else if (nxt > m_hwm) m_hwm = nxt;
    m_count = nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n, input logic v);
    reset       = 1'b1;
    i_in_valid  = v;
    i_in_data   = 4'h9;
    i_out_ready = 1'b1;
    i_hwm_clear = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset       = 1'b0;
    i_in_valid  = 1'b0;
    i_out_ready = 1'b0;
    q.delete();
    m_count = 0;
    m_hwm   = 0;
    m_hold  = 4'h0;
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    reset       = 1'b1;
    i_in_valid  = 1'b0;
    i_in_data   = 4'h0;
    i_out_ready = 1'b0;
    i_hwm_clear = 1'b0;
    m_count     = 0;
    m_hwm       = 0;
    m_hold      = 4'h0;

    // reset then idle
    do_reset(2, 1'b0);
    cycle(1'b0, 4'h0, 1'b0, 1'b0);

    // fill, refused fifth push, drain in order, hold last word
    cycle(1'b1, 4'h3, 1'b0, 1'b0);
    cycle(1'b1, 4'h7, 1'b0, 1'b0);
    cycle(1'b1, 4'hA, 1'b0, 1'b0);
    cycle(1'b1, 4'hC, 1'b0, 1'b0);
    cycle(1'b1, 4'hF, 1'b0, 1'b0);
    repeat (4) cycle(1'b0, 4'h0, 1'b1, 1'b0);
    cycle(1'b0, 4'h0, 1'b0, 1'b0);
    chk("held_last", 32'(o_out_data), 32'h0000000C);

    // streaming with simultaneous push/pop
    for (int i = 0; i < 16; i++) cycle(1'b1, 4'(i), 1'b1, 1'b0);
    cycle(1'b0, 4'h0, 1'b1, 1'b0);
    cycle(1'b0, 4'h0, 1'b0, 1'b0);

    // full with pop: push refused, accepted on the next cycle
    repeat (4) cycle(1'b1, 4'($urandom), 1'b0, 1'b0);
    cycle(1'b1, 4'h5, 1'b1, 1'b0);
    cycle(1'b1, 4'h5, 1'b0, 1'b0);
    cycle(1'b0, 4'h0, 1'b0, 1'b0);
    repeat (4) cycle(1'b0, 4'h0, 1'b1, 1'b0);
    cycle(1'b0, 4'h0, 1'b0, 1'b0);

    // pointer wrap
    repeat (10) begin
      repeat (3) cycle(1'b1, 4'($urandom), 1'b0, 1'b0);
      repeat (3) cycle(1'b0, 4'h0, 1'b1, 1'b0);
    end
    cycle(1'b0, 4'h0, 1'b0, 1'b0);

    // hwm clear keeps current occupancy, then reset mid-stream
    cycle(1'b1, 4'h1, 1'b0, 1'b0);
    cycle(1'b1, 4'h2, 1'b0, 1'b0);
    cycle(1'b0, 4'h0, 1'b0, 1'b1);
    cycle(1'b1, 4'h6, 1'b0, 1'b0);
    cycle(1'b0, 4'h0, 1'b0, 1'b0);
    do_reset(1, 1'b1);
    cycle(1'b0, 4'h0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
